// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the multicycle-operation sequencer.
//   SEQ_IDLE/SEQ_RUN/SEQ_DONE : state encodings (2'd3 is unused and treated as idle)
//   SEQ_WIDTH_DEF / SEQ_LIMIT_DEF : default counter width and terminal count
//   seq_accept()  : start request qualified by abort (abort always wins)
package cycle_sequencer_pkg;

   localparam int unsigned SEQ_WIDTH_DEF = 5;
   localparam int unsigned SEQ_LIMIT_DEF = 31;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_e;

   function automatic logic seq_accept(input logic start, input logic abort);
      return start & ~abort;
   endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Handshake bundle between a requester (master) and the sequencer (slave).
//   start, abort, en, limit : requester -> sequencer
//   q, busy, last, done     : sequencer -> requester
import cycle_sequencer_pkg::*;

interface cycle_sequencer_if #(parameter int unsigned WIDTH = SEQ_WIDTH_DEF);
   logic             start;
   logic             abort;
   logic             en;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             last;
   logic             done;

   modport master (output start, abort, en, limit, input q, busy, last, done);
   modport slave  (input start, abort, en, limit, output q, busy, last, done);
endinterface

// File: rtl/sync_counter_n.sv
// WIDTH-bit synchronous up-counter.
//   clk       : clock
//   clr       : synchronous active-high reset to zero
//   load_zero : synchronous return to zero, overrides en
//   en        : count enable (+1 modulo 2^WIDTH)
//   q         : count value
module sync_counter_n #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_zero,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)            q <= '0;
      else if (load_zero) q <= '0;
      else if (en)        q <= q + WIDTH'(1);
   end

endmodule

// File: rtl/cycle_sequencer.sv
// Multicycle-operation sequencer: on an accepted start, steps q through
// 0..limit_r on enabled clocks, flags the final step with last, then pulses done.
//   clk  : clock
//   clr  : synchronous active-high reset, dominates all other inputs
//   bus  : slave side of cycle_sequencer_if (start/abort/en/limit in, q/busy/last/done out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SEQ_IDLE | waiting for start; q held at 0
// SEQ_RUN  | operation in progress; q advances on en, busy=1
// SEQ_DONE | single-cycle completion pulse; may restart back-to-back
import cycle_sequencer_pkg::*;

module cycle_sequencer #(
   parameter int unsigned WIDTH         = SEQ_WIDTH_DEF,
   parameter int unsigned DEFAULT_LIMIT = SEQ_LIMIT_DEF
) (
   input  logic               clk,
   input  logic               clr,
   cycle_sequencer_if.slave   bus
);

   seq_state_e       state;
   logic [WIDTH-1:0] limit_r;
   logic             busy_r;
   logic             done_r;
   logic             at_limit;
   logic             in_run;
   logic             cnt_zero;
   logic             cnt_inc;

   assign at_limit = (bus.q == limit_r);
   assign in_run   = (state == SEQ_RUN);

   // Outside RUN the counter is parked at zero, so any accepted start begins at 0.
   assign cnt_zero = ~in_run | bus.abort | (bus.en & at_limit);
   assign cnt_inc  = in_run & bus.en;

   sync_counter_n #(.WIDTH(WIDTH)) u_cnt (
      .clk       (clk),
      .clr       (clr),
      .load_zero (cnt_zero),
      .en        (cnt_inc),
      .q         (bus.q)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= SEQ_IDLE;
         limit_r <= WIDTH'(DEFAULT_LIMIT);
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state)
            SEQ_RUN: begin
               done_r <= 1'b0;
               if (bus.abort) begin
                  state  <= SEQ_IDLE;
                  busy_r <= 1'b0;
               end else if (bus.en && at_limit) begin
                  state  <= SEQ_DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            // IDLE, DONE and the unused encoding all accept a new start.
            default: begin
               done_r <= 1'b0;
               if (seq_accept(bus.start, bus.abort)) begin
                  state   <= SEQ_RUN;
                  limit_r <= bus.limit;
                  busy_r  <= 1'b1;
               end else begin
                  state   <= SEQ_IDLE;
                  busy_r  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.last = busy_r & at_limit;

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;

   localparam int W = 5;

   logic clk = 1'b0;
   logic clr;

   cycle_sequencer_if #(.WIDTH(W)) bus ();

   cycle_sequencer #(.WIDTH(W), .DEFAULT_LIMIT(31)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: running flag, iteration index, terminal count, done pulse
   bit m_run  = 0;
   bit m_done = 0;
   int m_q    = 0;
   int m_lim  = 31;

   // per-scenario observations
   int busy_cyc, done_cnt, last_cnt, max_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic scen_clear();
      busy_cyc = 0; done_cnt = 0; last_cnt = 0; max_q = 0;
   endtask

   task automatic step(input bit c, input bit s, input bit a, input bit e, input int l);
      clr       = c;
      bus.start = s;
      bus.abort = a;
      bus.en    = e;
      bus.limit = W'(l);
      @(posedge clk);
      if (c) begin
         m_run = 0; m_done = 0; m_q = 0; m_lim = 31;
      end else if (m_run) begin
         m_done = 0;
         if (a) begin
            m_run = 0; m_q = 0;
         end else if (e) begin
            if (m_q == m_lim) begin
               m_run = 0; m_done = 1; m_q = 0;
            end else begin
               m_q = m_q + 1;
            end
         end
      end else begin
         m_done = 0;
         if (s && !a) begin
            m_run = 1; m_q = 0; m_lim = l % (1 << W);
         end
      end
      #1;
      chk("q",    32'(bus.q),    32'(m_q));
      chk("busy", 32'(bus.busy), 32'(m_run));
      chk("last", 32'(bus.last), 32'(m_run && (m_q == m_lim)));
      chk("done", 32'(bus.done), 32'(m_done));
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.last === 1'b1) last_cnt++;
      if (int'(bus.q) > max_q) max_q = int'(bus.q);
   endtask

   initial begin
      clr = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.en = 1'b0; bus.limit = '0;

      // 1: reset
      step(1, 0, 0, 0, 0);
      chk("rst_q",     32'(bus.q), 0);
      chk("rst_busy",  32'(bus.busy), 0);
      chk("rst_done",  32'(bus.done), 0);
      chk("rst_last",  32'(bus.last), 0);
      chk("rst_limit", 32'(dut.limit_r), 31);

      // 2: limit=3, continuous enable
      scen_clear();
      step(0, 1, 0, 1, 3);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 9);
      chk("t2_busy", busy_cyc, 4);
      chk("t2_last", last_cnt, 1);
      chk("t2_done", done_cnt, 1);

      // 3: stall for 2 cycles at q=1
      scen_clear();
      step(0, 1, 0, 1, 3);
      step(0, 0, 0, 1, 0);
      chk("t3_q1", 32'(bus.q), 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t3_hold_q", 32'(bus.q), 1);
      chk("t3_hold_busy", 32'(bus.busy), 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
      chk("t3_busy", busy_cyc, 6);
      chk("t3_done", done_cnt, 1);

      // 4: full-range run, no wrap
      scen_clear();
      step(0, 1, 0, 1, 31);
      for (int i = 0; i < 34; i++) step(0, 0, 0, 1, 0);
      chk("t4_busy", busy_cyc, 32);
      chk("t4_maxq", max_q, 31);
      chk("t4_done", done_cnt, 1);

      // 5: abort at q=2, then start+abort in idle
      scen_clear();
      step(0, 1, 0, 1, 6);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("t5_q2", 32'(bus.q), 2);
      step(0, 0, 1, 1, 0);
      chk("t5_ab_busy", 32'(bus.busy), 0);
      chk("t5_ab_q", 32'(bus.q), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(0, 1, 1, 1, 4);
      chk("t5_sa_busy", 32'(bus.busy), 0);
      chk("t5_done", done_cnt, 0);

      // 6: back-to-back restart from DONE with limit=0, then clr mid-run
      scen_clear();
      step(0, 1, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("t6_done1", 32'(bus.done), 1);
      step(0, 1, 0, 0, 0);
      chk("t6_rs_busy", 32'(bus.busy), 1);
      chk("t6_rs_last", 32'(bus.last), 1);
      step(0, 0, 0, 1, 0);
      chk("t6_done2", 32'(bus.done), 1);
      step(0, 1, 0, 1, 20);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("t6_clr_busy", 32'(bus.busy), 0);
      chk("t6_clr_limit", 32'(dut.limit_r), 31);
      step(0, 0, 0, 1, 0);
      chk("t6_done_total", done_cnt, 2);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         automatic bit c = ($urandom_range(0, 199) == 0);
         automatic bit s = ($urandom_range(0, 3) == 0);
         automatic bit a = ($urandom_range(0, 29) == 0);
         automatic bit e = ($urandom_range(0, 3) != 0);
         automatic int l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                                       : int'($urandom_range(0, 5));
         step(c, s, a, e, l);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
